// File: rtl/pipe_control_hazard.sv
// pipe_control_hazard: main decoder, D->E / E->M / M->W control pipeline
// and hazard unit (stalls, flush, forwarding) for the 5-stage MIPS core.
// Optional macro PIPE_HAZARD_PERF_CNT_EN adds stall/branch performance
// counters; without it both counter ports are tied to zero.
module pipe_control_hazard #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             equalD,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  output logic             pcsrcD,
  output logic             regdstE,
  output logic             alusrcE,
  output logic [2:0]       alucontrolE,
  output logic             memwriteM,
  output logic             memtoregW,
  output logic             regwriteW,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic [CNT_W-1:0] stallcount,
  output logic [CNT_W-1:0] branchcount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

  // Decode-stage control
  logic       regwriteD, regdstD, alusrcD, branchD, memwriteD, memtoregD;
  logic [2:0] alucontrolD;
  // Pipelined control not exported as ports
  logic       regwriteE, memtoregE, memwriteE;
  logic       regwriteM, memtoregM;
  logic       lwstall, branchstall, hazard;

  // E-stage forward select: M result wins over W; $0 never forwards.
  function automatic logic [1:0] fwdSelE(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] wrM,
                                         input logic             wenM,
                                         input logic [REG_W-1:0] wrW,
                                         input logic             wenW);
    if ((src != REG_ZERO) && (src == wrM) && wenM) begin
      return 2'b10;
    end else if ((src != REG_ZERO) && (src == wrW) && wenW) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Main decoder: unsupported op/funct decode to an all-zero bubble.
  always_comb begin
    regwriteD   = 1'b0;
    regdstD     = 1'b0;
    alusrcD     = 1'b0;
    branchD     = 1'b0;
    memwriteD   = 1'b0;
    memtoregD   = 1'b0;
    alucontrolD = 3'b000;
    case (op)
      OP_RTYPE: begin
        case (funct)
          6'b100000: begin regwriteD = 1'b1; regdstD = 1'b1; alucontrolD = 3'b010; end
          6'b100010: begin regwriteD = 1'b1; regdstD = 1'b1; alucontrolD = 3'b110; end
          6'b100100: begin regwriteD = 1'b1; regdstD = 1'b1; alucontrolD = 3'b000; end
          6'b100101: begin regwriteD = 1'b1; regdstD = 1'b1; alucontrolD = 3'b001; end
          6'b101010: begin regwriteD = 1'b1; regdstD = 1'b1; alucontrolD = 3'b111; end
          default:   begin regwriteD = 1'b0; regdstD = 1'b0; alucontrolD = 3'b000; end
        endcase
      end
      OP_LW:   begin regwriteD = 1'b1; alusrcD = 1'b1; memtoregD = 1'b1; alucontrolD = 3'b010; end
      OP_SW:   begin alusrcD = 1'b1; memwriteD = 1'b1; alucontrolD = 3'b010; end
      OP_BEQ:  begin branchD = 1'b1; alucontrolD = 3'b110; end
      OP_ADDI: begin regwriteD = 1'b1; alusrcD = 1'b1; alucontrolD = 3'b010; end
      default: begin regwriteD = 1'b0; alucontrolD = 3'b000; end
    endcase
  end

  // Branch resolution, forwarding selects and stall/flush generation.
  always_comb begin
    pcsrcD      = branchD & equalD;
    forwardAE   = fwdSelE(rsE, writeregM, regwriteM, writeregW, regwriteW);
    forwardBE   = fwdSelE(rtE, writeregM, regwriteM, writeregW, regwriteW);
    forwardAD   = (rsD != REG_ZERO) && (rsD == writeregM) && regwriteM;
    forwardBD   = (rtD != REG_ZERO) && (rtD == writeregM) && regwriteM;
    lwstall     = memtoregE & ((rtE == rsD) | (rtE == rtD));
    branchstall = branchD &
                  ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                   (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
    hazard      = lwstall | branchstall;
    stallF      = hazard;
    stallD      = hazard;
    flushE      = hazard;
  end

  // D->E control register: reset or flush inserts a bubble.
  always_ff @(posedge clk) begin
    if (!reset || flushE) begin
      regwriteE   <= 1'b0;
      memtoregE   <= 1'b0;
      memwriteE   <= 1'b0;
      alucontrolE <= 3'b000;
      alusrcE     <= 1'b0;
      regdstE     <= 1'b0;
    end else begin
      regwriteE   <= regwriteD;
      memtoregE   <= memtoregD;
      memwriteE   <= memwriteD;
      alucontrolE <= alucontrolD;
      alusrcE     <= alusrcD;
      regdstE     <= regdstD;
    end
  end

  // E->M and M->W control registers advance every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regwriteM <= 1'b0;
      memtoregM <= 1'b0;
      memwriteM <= 1'b0;
      regwriteW <= 1'b0;
      memtoregW <= 1'b0;
    end else begin
      regwriteM <= regwriteE;
      memtoregM <= memtoregE;
      memwriteM <= memwriteE;
      regwriteW <= regwriteM;
      memtoregW <= memtoregM;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt, branchCnt;

  // Performance counters: count stall and taken-branch edges, wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stallCnt  <= {CNT_W{1'b0}};
      branchCnt <= {CNT_W{1'b0}};
    end else begin
      stallCnt  <= stallF ? stallCnt + {{(CNT_W-1){1'b0}}, 1'b1} : stallCnt;
      branchCnt <= pcsrcD ? branchCnt + {{(CNT_W-1){1'b0}}, 1'b1} : branchCnt;
    end
  end

  assign stallcount  = stallCnt;
  assign branchcount = branchCnt;
`else
  assign stallcount  = {CNT_W{1'b0}};
  assign branchcount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_control_hazard.sv
// Directed self-checking bench for pipe_control_hazard.
// Counters use a 2-bit width so wrap-around is reachable quickly.
module tb_pipe_control_hazard;
  localparam int CNT_W = 2;
  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       op, funct;
  logic             equalD;
  logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic             pcsrcD, regdstE, alusrcE, memwriteM, memtoregW, regwriteW;
  logic [2:0]       alucontrolE;
  logic             stallF, stallD, flushE, forwardAD, forwardBD;
  logic [1:0]       forwardAE, forwardBE;
  logic [CNT_W-1:0] stallcount, branchcount;

  int nChecks = 0;
  int nFails  = 0;

  pipe_control_hazard #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .equalD(equalD),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .pcsrcD(pcsrcD), .regdstE(regdstE), .alusrcE(alusrcE),
    .alucontrolE(alucontrolE), .memwriteM(memwriteM), .memtoregW(memtoregW),
    .regwriteW(regwriteW), .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallcount(stallcount), .branchcount(branchcount)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  int expStall3, expBranch2, expWrap;

  initial begin
`ifdef PIPE_HAZARD_PERF_CNT_EN
    expStall3 = 3; expBranch2 = 2; expWrap = 0;
`else
    expStall3 = 0; expBranch2 = 0; expWrap = 0;
`endif
    reset = 1'b0; op = 6'b000000; funct = 6'b100000; equalD = 1'b0;
    rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
    writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
    tick(); tick();
    // Reset held: everything quiet even though an add is being decoded
    checkVal("rst_regdstE", {31'd0, regdstE}, 32'd0);
    checkVal("rst_alusrcE", {31'd0, alusrcE}, 32'd0);
    checkVal("rst_aluctlE", {29'd0, alucontrolE}, 32'd0);
    checkVal("rst_memwriteM", {31'd0, memwriteM}, 32'd0);
    checkVal("rst_memtoregW", {31'd0, memtoregW}, 32'd0);
    checkVal("rst_regwriteW", {31'd0, regwriteW}, 32'd0);
    checkVal("rst_stallF", {31'd0, stallF}, 32'd0);
    checkVal("rst_flushE", {31'd0, flushE}, 32'd0);
    checkVal("rst_fwdAE", {30'd0, forwardAE}, 32'd0);
    checkVal("rst_pcsrcD", {31'd0, pcsrcD}, 32'd0);
    checkVal("rst_stallcnt", {30'd0, stallcount}, 32'd0);

    reset = 1'b1;
    tick();  // add #1 in E, add #2 in D
    checkVal("add_aluctlE", {29'd0, alucontrolE}, 32'd2);
    checkVal("add_regdstE", {31'd0, regdstE}, 32'd1);
    checkVal("add_alusrcE", {31'd0, alusrcE}, 32'd0);
    tick();  // add #1 in M, add #2 in E
    op = 6'b111111;
    checkVal("add_regwriteW_early", {31'd0, regwriteW}, 32'd0);
    tick();  // add #1 in W, add #2 in M, bubble in E
    checkVal("add_regwriteW", {31'd0, regwriteW}, 32'd1);
    checkVal("add_memtoregW", {31'd0, memtoregW}, 32'd0);
    checkVal("unk_aluctlE", {29'd0, alucontrolE}, 32'd0);
    checkVal("unk_regdstE", {31'd0, regdstE}, 32'd0);
    equalD = 1'b1; settle();
    checkVal("unk_pcsrcD", {31'd0, pcsrcD}, 32'd0);
    equalD = 1'b0;
    // Forwarding with regwriteM = regwriteW = 1
    rsE = 5'd3; writeregM = 5'd3; writeregW = 5'd3; settle();
    checkVal("fwdAE_MoverW", {30'd0, forwardAE}, 32'd2);
    writeregM = 5'd4; settle();
    checkVal("fwdAE_W", {30'd0, forwardAE}, 32'd1);
    rtE = 5'd3; settle();
    checkVal("fwdBE_W", {30'd0, forwardBE}, 32'd1);
    rsE = 5'd0; writeregM = 5'd0; writeregW = 5'd0; settle();
    checkVal("fwdAE_zero", {30'd0, forwardAE}, 32'd0);
    rsD = 5'd3; writeregM = 5'd3; settle();
    checkVal("fwdAD_hit", {31'd0, forwardAD}, 32'd1);
    rtD = 5'd0; writeregM = 5'd0; settle();
    checkVal("fwdBD_zero", {31'd0, forwardBD}, 32'd0);
    rsD = 5'd0; rtE = 5'd0;
    tick();  // add #2 in W
    tick();  // bubble in W
    checkVal("unk_regwriteW", {31'd0, regwriteW}, 32'd0);
    checkVal("unk_memwriteM", {31'd0, memwriteM}, 32'd0);
    checkVal("unk_memtoregW", {31'd0, memtoregW}, 32'd0);

    // Load-use stall
    op = 6'b100011;
    tick();  // lw in E
    checkVal("lw_alusrcE", {31'd0, alusrcE}, 32'd1);
    rtE = 5'd5; rsD = 5'd5; op = 6'b000000; funct = 6'b100000; settle();
    checkVal("lw_stallF", {31'd0, stallF}, 32'd1);
    checkVal("lw_stallD", {31'd0, stallD}, 32'd1);
    checkVal("lw_flushE", {31'd0, flushE}, 32'd1);
    tick();  // bubble in E
    checkVal("lw_bubble_aluctlE", {29'd0, alucontrolE}, 32'd0);
    checkVal("lw_bubble_alusrcE", {31'd0, alusrcE}, 32'd0);
    checkVal("lw_stall_cleared", {31'd0, stallF}, 32'd0);
    tick();  // add in E, lw in W
    checkVal("lw_memtoregW", {31'd0, memtoregW}, 32'd1);
    checkVal("add2_aluctlE", {29'd0, alucontrolE}, 32'd2);

    // beq depending on the add in E
    rtE = 5'd0; rsD = 5'd2; rtD = 5'd7; writeregE = 5'd2; op = 6'b000100; settle();
    checkVal("beq_stall", {31'd0, stallF}, 32'd1);
    checkVal("beq_pcsrc_nt", {31'd0, pcsrcD}, 32'd0);
    tick();  // bubble in E
    equalD = 1'b1; settle();
    checkVal("beq_stall_cleared", {31'd0, stallF}, 32'd0);
    checkVal("beq_pcsrcD", {31'd0, pcsrcD}, 32'd1);
    tick();  // beq in E
    checkVal("beq_aluctlE", {29'd0, alucontrolE}, 32'd6);
    op = 6'b101011; equalD = 1'b0;
    tick();  // sw in E
    checkVal("sw_alusrcE", {31'd0, alusrcE}, 32'd1);
    checkVal("sw_regdstE", {31'd0, regdstE}, 32'd0);
    op = 6'b111111;
    tick();
    checkVal("sw_memwriteM", {31'd0, memwriteM}, 32'd1);
    tick();
    checkVal("sw_memwriteM_off", {31'd0, memwriteM}, 32'd0);

    // Reset while a lw is in flight
    op = 6'b100011; rsD = 5'd1; rtD = 5'd1; rtE = 5'd0; writeregE = 5'd0;
    tick();  // lw in E
    reset = 1'b0; op = 6'b111111;
    tick();
    checkVal("midrst_alusrcE", {31'd0, alusrcE}, 32'd0);
    checkVal("midrst_aluctlE", {29'd0, alucontrolE}, 32'd0);
    reset = 1'b1;
    tick();  // lw would be in W without reset
    checkVal("midrst_memtoregW", {31'd0, memtoregW}, 32'd0);
    checkVal("cnt_zero_stall", {30'd0, stallcount}, 32'd0);
    checkVal("cnt_zero_branch", {30'd0, branchcount}, 32'd0);

    // Three load-use stalls then two taken branches
    rtE = 5'd5;
    for (int i = 0; i < 3; i++) begin
      op = 6'b100011; rsD = 5'd5;
      tick();
      op = 6'b000000; funct = 6'b100000; settle();
      checkVal("cnt_stall_on", {31'd0, stallF}, 32'd1);
      tick();
    end
    writeregM = 5'd9; rsD = 5'd1; rtD = 5'd1; rtE = 5'd0; op = 6'b000100; equalD = 1'b1;
    settle();
    checkVal("cnt_br_nostall", {31'd0, stallF}, 32'd0);
    tick();
    tick();
    op = 6'b111111; equalD = 1'b0;
    checkVal("cnt_stallcount", {30'd0, stallcount}, expStall3);
    checkVal("cnt_branchcount", {30'd0, branchcount}, expBranch2);
    // Fourth stall wraps the 2-bit stall counter
    op = 6'b100011; rsD = 5'd5; rtE = 5'd5;
    tick();
    op = 6'b000000; settle();
    tick();
    checkVal("cnt_stall_wrap", {30'd0, stallcount}, expWrap);
    checkVal("cnt_branch_hold", {30'd0, branchcount}, expBranch2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/pipe_control_hazard.md
Name: pipe_control_hazard

Overview:
Pipelined main controller plus hazard unit for the 5-stage MIPS core.
- Consumes the decode-stage opcode/funct, branch compare result and register specifiers that the pipelined datapath exports.
- Returns every control and hazard input the datapath needs: pcsrc, regdst, alusrc, alucontrol, memwrite, memtoreg, regwrite, stalls, flush and forwarding selects.
- Holds its own D→E, E→M and M→W control pipeline registers, so control always stays aligned with the datapath's stage registers.

Parameters:
- CNT_W, 32, width of the optional performance counters.
- REG_W, 5, register-specifier width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- op  in  6  instrD[31:26].
- funct  in  6  instrD[5:0].
- equalD  in  1  decode-stage operand equality.
- rsD, rtD, rsE, rtE  in  REG_W each  source specifiers in D and E.
- writeregE, writeregM, writeregW  in  REG_W each  destination register per stage.
- pcsrcD  out  1  take branch.
- regdstE, alusrcE  out  1 each.
- alucontrolE  out  3.
- memwriteM, memtoregW, regwriteW  out  1 each.
- stallF, stallD, flushE  out  1 each.
- forwardAD, forwardBD  out  1 each.
- forwardAE, forwardBE  out  2 each.
- stallcount, branchcount  out  CNT_W each  performance counters (see Optional Feature).

Behaviour:
- Decode (combinational, D stage). Fields: {regwrite, regdst, alusrc, branch, memwrite, memtoreg, alucontrol}.
  - R-type op=000000 → regwrite=1, regdst=1. funct decodes alucontrol: 100000→010 add, 100010→110 sub, 100100→000 and, 100101→001 or, 101010→111 slt. Any other funct, including 000000 NOP → all controls 0.
  - lw 100011 → regwrite, alusrc, memtoreg; alucontrol=010.
  - sw 101011 → alusrc, memwrite; alucontrol=010.
  - beq 000100 → branch; alucontrol=110.
  - addi 001000 → regwrite, alusrc; alucontrol=010.
  - Any other op → all controls 0 (bubble).
- pcsrcD = branchD & equalD. Combinational, same cycle as decode.
- D→E register: regwrite, memtoreg, memwrite, alucontrol, alusrc, regdst.
  - Loads 0 on reset or flushE.
  - Otherwise loads the decoded values every cycle.
- E→M register: regwrite, memtoreg, memwrite. Loads every cycle; 0 on reset.
- M→W register: regwrite, memtoreg. Loads every cycle; 0 on reset.
- Latency: a control field reaches its E/M/W output exactly 1/2/3 cycles after the instruction is in D.
- Forwarding to E (forwardBE identical, with rtE in place of rsE):
  - forwardAE = 10 if rsE≠0 & rsE==writeregM & regwriteM.
  - else 01 if rsE≠0 & rsE==writeregW & regwriteW.
  - else 00.
  - M has priority over W when both match.
- Forwarding to D: forwardAD = rsD≠0 & rsD==writeregM & regwriteM. forwardBD is the same with rtD.
- Hazard detection:
  - lwstall = memtoregE & (rtE==rsD | rtE==rtD).
  - branchstall = branchD & ((regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD))).
  - stallF = stallD = flushE = lwstall | branchstall.
- Register $0 never forwards. Stalls are not gated on $0, which is a conservative extra bubble.
- Reset values: all pipeline registers 0. Hence memwriteM, memtoregW, regwriteW, regdstE, alusrcE = 0 and alucontrolE = 000. forwardAE/BE = 00, forwardAD/BD = 0, stallF/stallD/flushE = 0. pcsrcD = 0 while the decoded instruction is not beq.
- Reset asserted mid-instruction: all in-flight control is discarded on the next edge. Reset dominates flushE.
- Simultaneous stall and pcsrcD: both outputs assert. The datapath resolves it (flushes D, holds F).

Optional Feature:
Macro PIPE_HAZARD_PERF_CNT_EN.
- Defined:
  - stallcount increments by 1 on each clk edge with stallF=1.
  - branchcount increments on each edge with pcsrcD=1.
  - Both are CNT_W-bit, wrap to 0 after all-ones, and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Reset held low 2 cycles, op=000000 funct=100000 applied → after release, alucontrolE=010, regdstE=1 one cycle later; regwriteW=1 three cycles after decode; all outputs 0 during reset.
- add $3 in M (writeregM=3, regwriteM=1) and rsE=3 while writeregW=3 also writes → forwardAE=10. With rsE=0 and writeregM=0 → forwardAE=00.
- lw in E (memtoregE=1, rtE=5), D holds rsD=5 → stallF=stallD=flushE=1 for exactly one cycle; next cycle alucontrolE=000, regwriteE bubble=0.
- beq in D (op=000100, rsD=2) with writeregE=2 and regwriteE=1 → stall asserted; one cycle later, equalD=1 → pcsrcD=1, stall=0.
- Unknown op=111111 → all E/M/W controls 0 after propagation; pcsrcD=0.
- With PIPE_HAZARD_PERF_CNT_EN: 3 stall cycles plus 2 taken branches → stallcount=3, branchcount=2. Counters preloaded to all-ones by forcing wrap to 0. Without the macro, both read 0.
